// File: rtl/adau_ctrl_arbiter.sv
// rtl/adau_ctrl_arbiter.sv - two-port SPI command arbiter (boot list + CPU FIFO) with idle gap
// CPU writes are queued; the boot list and the queue are round-robined once init_done is high.
module adau_ctrl_arbiter #(
   parameter int CMD_WIDTH  = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int GAP_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [CMD_WIDTH-1:0]          init_cmd,
   input  logic                          init_valid,
   output logic                          init_ready,
   input  logic                          init_done,
   input  logic [CMD_WIDTH-1:0]          cpu_cmd,
   input  logic                          cpu_wr,
   output logic                          cpu_full,
   output logic [$clog2(FIFO_DEPTH):0]   cpu_level,
   output logic                          cpu_ovf,
   input  logic                          cpu_ovf_clr,
   output logic [CMD_WIDTH-1:0]          m_cmd,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          busy,
   output logic                          owner
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_e;

   state_e               state_q, state_d;
   logic                 owner_q, owner_d;
   logic                 rr_q, rr_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic [CMD_WIDTH-1:0] m_cmd_q, m_cmd_d;
   logic [LW-1:0]        level_q, level_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic                 ovf_q, ovf_d;
   logic [CMD_WIDTH-1:0] mem [FIFO_DEPTH];

   logic full, cpu_pend, xfer, push, pop, sel;

   always_comb begin
      // Full comes from the registered level, so a same-cycle pop never rescues a write.
      full     = (level_q == LW'(FIFO_DEPTH));
      cpu_pend = init_done && (level_q != '0);
      xfer     = (state_q == S_GRANT) && m_ready;
      push     = cpu_wr && !full;
      pop      = xfer && owner_q;
      sel      = 1'b0;

      state_d  = state_q;
      owner_d  = owner_q;
      rr_d     = rr_q;
      gap_d    = gap_q;
      m_cmd_d  = m_cmd_q;

      case (state_q)
         S_IDLE: begin
            if (init_valid || cpu_pend) begin
               // rr_q names the port favoured on a tie: 0 = INIT, 1 = CPU.
               sel     = cpu_pend && (!init_valid || rr_q);
               state_d = S_GRANT;
               owner_d = sel;
               rr_d    = !sel;
               m_cmd_d = sel ? mem[rd_ptr_q] : init_cmd;
            end
         end
         S_GRANT: begin
            if (m_ready) begin
               state_d = S_GAP;
               gap_d   = GW'(GAP_CYCLES - 1);
            end
         end
         S_GAP: begin
            if (gap_q == '0) state_d = S_IDLE;
            else             gap_d   = gap_q - GW'(1);
         end
         default: state_d = S_IDLE;
      endcase

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      if (cpu_wr && full)  ovf_d = 1'b1;
      else if (cpu_ovf_clr) ovf_d = 1'b0;
      else                  ovf_d = ovf_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         rr_q     <= 1'b0;
         gap_q    <= '0;
         m_cmd_q  <= '0;
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         gap_q    <= gap_d;
         m_cmd_q  <= m_cmd_d;
         level_q  <= level_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= cpu_cmd;
   end

   assign m_valid    = (state_q == S_GRANT);
   assign init_ready = xfer && !owner_q;
   assign busy       = (state_q != S_IDLE);
   assign owner      = owner_q;
   assign m_cmd      = m_cmd_q;
   assign cpu_level  = level_q;
   assign cpu_full   = full;
   assign cpu_ovf    = ovf_q;

endmodule

// File: tb/tb_adau_ctrl_arbiter.sv
// tb/tb_adau_ctrl_arbiter.sv - directed vector bench for adau_ctrl_arbiter
module tb_adau_ctrl_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] init_cmd;
   logic        init_valid;
   logic        init_ready;
   logic        init_done;
   logic [31:0] cpu_cmd;
   logic        cpu_wr;
   logic        cpu_full;
   logic [3:0]  cpu_level;
   logic        cpu_ovf;
   logic        cpu_ovf_clr;
   logic [31:0] m_cmd;
   logic        m_valid;
   logic        m_ready;
   logic        busy;
   logic        owner;

   int tests = 0;
   int fails = 0;

   adau_ctrl_arbiter #(.CMD_WIDTH(32), .FIFO_DEPTH(8), .GAP_CYCLES(4)) dut (
      .clk(clk), .rstn(rstn),
      .init_cmd(init_cmd), .init_valid(init_valid), .init_ready(init_ready), .init_done(init_done),
      .cpu_cmd(cpu_cmd), .cpu_wr(cpu_wr), .cpu_full(cpu_full), .cpu_level(cpu_level),
      .cpu_ovf(cpu_ovf), .cpu_ovf_clr(cpu_ovf_clr),
      .m_cmd(m_cmd), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] icmd;
      logic        idone;
      logic        cwr;
      logic [31:0] ccmd;
      logic        mrdy;
      logic        e_mv;
      logic [31:0] e_cmd;
      logic        e_ir;
      logic        e_busy;
      logic        e_own;
      logic [3:0]  e_lvl;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mk(logic iv, logic [31:0] icmd, logic idone, logic cwr,
                               logic [31:0] ccmd, logic mrdy, logic e_mv, logic [31:0] e_cmd,
                               logic e_ir, logic e_busy, logic e_own, logic [3:0] e_lvl);
      vec_t v;
      v.iv = iv; v.icmd = icmd; v.idone = idone; v.cwr = cwr; v.ccmd = ccmd; v.mrdy = mrdy;
      v.e_mv = e_mv; v.e_cmd = e_cmd; v.e_ir = e_ir; v.e_busy = e_busy; v.e_own = e_own;
      v.e_lvl = e_lvl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      init_cmd = '0; init_valid = 1'b0; init_done = 1'b0;
      cpu_cmd = '0; cpu_wr = 1'b0; cpu_ovf_clr = 1'b0; m_ready = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] C1 = 32'h00C0_0001;
   localparam logic [31:0] C2 = 32'h00C0_0002;
   localparam logic [31:0] A1 = 32'hA000_0001;
   localparam logic [31:0] A2 = 32'hA000_0002;
   localparam logic [31:0] A3 = 32'hA000_0003;

   initial begin
      int got;
      logic [31:0] exp_cmd;

      // boot command, second boot command waiting through GAP, CPU gating, first CPU grant
      vecs[0]  = mk(0, 0,  0, 0, 0,  0,  0, 0,  0, 0, 0, 0);
      vecs[1]  = mk(1, C1, 0, 0, 0,  1,  0, 0,  0, 0, 0, 0);
      vecs[2]  = mk(1, C1, 0, 0, 0,  1,  1, C1, 1, 1, 0, 0);
      vecs[3]  = mk(1, C2, 0, 0, 0,  1,  0, C1, 0, 1, 0, 0);
      vecs[4]  = mk(1, C2, 0, 0, 0,  1,  0, C1, 0, 1, 0, 0);
      vecs[5]  = mk(1, C2, 0, 0, 0,  1,  0, C1, 0, 1, 0, 0);
      vecs[6]  = mk(1, C2, 0, 0, 0,  1,  0, C1, 0, 1, 0, 0);
      vecs[7]  = mk(1, C2, 0, 0, 0,  1,  0, C1, 0, 0, 0, 0);
      vecs[8]  = mk(1, C2, 0, 0, 0,  1,  1, C2, 1, 1, 0, 0);
      vecs[9]  = mk(0, 0,  0, 1, A1, 1,  0, C2, 0, 1, 0, 0);
      vecs[10] = mk(0, 0,  0, 1, A2, 1,  0, C2, 0, 1, 0, 1);
      vecs[11] = mk(0, 0,  0, 1, A3, 1,  0, C2, 0, 1, 0, 2);
      vecs[12] = mk(0, 0,  0, 0, 0,  1,  0, C2, 0, 1, 0, 3);
      vecs[13] = mk(0, 0,  0, 0, 0,  1,  0, C2, 0, 0, 0, 3);
      vecs[14] = mk(0, 0,  0, 0, 0,  1,  0, C2, 0, 0, 0, 3);
      vecs[15] = mk(0, 0,  1, 0, 0,  1,  0, C2, 0, 0, 0, 3);
      vecs[16] = mk(0, 0,  1, 0, 0,  1,  1, A1, 0, 1, 1, 3);
      vecs[17] = mk(0, 0,  1, 0, 0,  1,  0, A1, 0, 1, 1, 2);

      do_reset();

      for (int i = 0; i < 18; i++) begin
         init_valid = vecs[i].iv;  init_cmd = vecs[i].icmd; init_done = vecs[i].idone;
         cpu_wr = vecs[i].cwr;     cpu_cmd = vecs[i].ccmd;  m_ready = vecs[i].mrdy;
         @(negedge clk);
         chk($sformatf("vec%0d.m_valid", i),    m_valid,    vecs[i].e_mv);
         chk($sformatf("vec%0d.m_cmd", i),      m_cmd,      vecs[i].e_cmd);
         chk($sformatf("vec%0d.init_ready", i), init_ready, vecs[i].e_ir);
         chk($sformatf("vec%0d.busy", i),       busy,       vecs[i].e_busy);
         chk($sformatf("vec%0d.owner", i),      owner,      vecs[i].e_own);
         chk($sformatf("vec%0d.level", i),      cpu_level,  vecs[i].e_lvl);
         next_cycle();
      end

      // remaining gated CPU commands drain in write order
      idle_inputs(); init_done = 1'b1; m_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && got < 2; c++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            exp_cmd = (got == 0) ? A2 : A3;
            chk($sformatf("gate.cmd%0d", got), m_cmd, exp_cmd);
            chk($sformatf("gate.owner%0d", got), owner, 1'b1);
            got++;
         end
         next_cycle();
      end
      chk("gate.count", got, 2);
      @(negedge clk);
      chk("gate.level", cpu_level, 0);
      next_cycle();

      // round robin with both ports continuously pending
      do_reset();
      got = 0;
      for (int c = 0; c < 100 && got < 4; c++) begin
         init_done = 1'b1; init_valid = 1'b1; init_cmd = 32'h1111_0000; m_ready = 1'b1;
         cpu_wr = (c < 3); cpu_cmd = 32'hD000_0000 + c;
         @(negedge clk);
         if (m_valid && m_ready) begin
            chk($sformatf("rr.owner%0d", got), owner, got % 2);
            exp_cmd = (got == 0) ? 32'h1111_0000 : (got == 1) ? 32'hD000_0000 :
                      (got == 2) ? 32'h1111_0000 : 32'hD000_0001;
            chk($sformatf("rr.cmd%0d", got), m_cmd, exp_cmd);
            got++;
         end
         next_cycle();
      end
      chk("rr.count", got, 4);

      // overflow: nine writes into eight entries, set beats clear
      do_reset();
      for (int i = 0; i < 9; i++) begin
         cpu_wr = 1'b1; cpu_cmd = 32'hB000_0000 + i;
         next_cycle();
      end
      cpu_wr = 1'b0;
      @(negedge clk);
      chk("ovf.level", cpu_level, 8);
      chk("ovf.full", cpu_full, 1);
      chk("ovf.sticky", cpu_ovf, 1);
      chk("ovf.no_grant", m_valid, 0);
      next_cycle();
      cpu_ovf_clr = 1'b1;
      next_cycle();
      cpu_ovf_clr = 1'b0;
      @(negedge clk);
      chk("ovf.cleared", cpu_ovf, 0);
      next_cycle();
      cpu_wr = 1'b1; cpu_ovf_clr = 1'b1; cpu_cmd = 32'hBAD0_0000;
      next_cycle();
      cpu_wr = 1'b0; cpu_ovf_clr = 1'b0;
      @(negedge clk);
      chk("ovf.set_priority", cpu_ovf, 1);
      chk("ovf.level_held", cpu_level, 8);
      next_cycle();
      cpu_ovf_clr = 1'b1;
      next_cycle();
      cpu_ovf_clr = 1'b0;
      init_done = 1'b1; m_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 200 && got < 12; c++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            if (got < 8) chk($sformatf("ovf.drain%0d", got), m_cmd, 32'hB000_0000 + got);
            got++;
         end
         next_cycle();
      end
      chk("ovf.drain_count", got, 8);
      chk("ovf.final_level", cpu_level, 0);
      chk("ovf.final_clear", cpu_ovf, 0);

      // backpressure: grant held 20 cycles without a pop
      m_ready = 1'b0; cpu_wr = 1'b1; cpu_cmd = 32'hC0DE_0001;
      next_cycle();
      cpu_wr = 1'b0;
      got = 0;
      for (int c = 0; c < 20 && got == 0; c++) begin
         @(negedge clk);
         if (m_valid) got = 1;
         else next_cycle();
      end
      chk("bp.granted", got, 1);
      next_cycle();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk($sformatf("bp.hold%0d", c), {m_valid, m_cmd, cpu_level}, {1'b1, 32'hC0DE_0001, 4'd1});
         next_cycle();
      end
      m_ready = 1'b1;
      @(negedge clk);
      chk("bp.xfer", {m_valid, owner, init_ready}, {1'b1, 1'b1, 1'b0});
      next_cycle();
      @(negedge clk);
      chk("bp.after", {m_valid, busy, cpu_level}, {1'b0, 1'b1, 4'd0});
      next_cycle();

      // asynchronous reset in the middle of a grant
      m_ready = 1'b0; init_valid = 1'b1; init_cmd = 32'hEEEE_0001;
      cpu_wr = 1'b1; cpu_cmd = 32'hE000_0001;
      next_cycle();
      cpu_wr = 1'b0;
      got = 0;
      for (int c = 0; c < 20 && got == 0; c++) begin
         @(negedge clk);
         if (m_valid) got = 1;
         else next_cycle();
      end
      chk("rst.granted", got, 1);
      #2;
      m_ready = 1'b1;
      rstn = 1'b0;
      #1;
      chk("rst.outputs",
          {m_cmd, m_valid, init_ready, cpu_full, cpu_level, cpu_ovf, busy, owner}, '0);
      @(posedge clk);
      #1;
      idle_inputs();
      rstn = 1'b1;
      @(negedge clk);
      chk("rst.level_after", cpu_level, 0);
      chk("rst.idle_after", {m_valid, busy}, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
